// File: rtl/nanov_fetch_pkg.sv
// nanov_fetch_pkg: shared types and constants for the bit-serial core's fetch
// sequencer.
//   fetch_state_t : sequencer states IDLE -> CMD -> ADDR -> FETCH -> EXEC
//   OP_*          : opcode[6:2] values that need a second execute cycle
//   DEFAULT_READ_CMD : SPI flash "read data" command byte
//   last_cycle()  : index of the final execute cycle for an instruction
package nanov_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        FETCH = 3'd3,
        EXEC  = 3'd4
    } fetch_state_t;

    localparam logic [4:0] OP_ALU_IMM = 5'b00100;
    localparam logic [4:0] OP_ALU     = 5'b01100;
    localparam logic [4:0] OP_STORE   = 5'b01000;

    localparam logic [7:0] DEFAULT_READ_CMD = 8'h03;

    // Shifts (funct3[1:0]=01 on ALU ops) and stores take two 32-clk cycles;
    // everything else completes in one.
    function automatic logic [2:0] last_cycle(input logic [4:0] op,
                                              input logic [1:0] f3_lo);
        if ((op == OP_ALU_IMM || op == OP_ALU) && f3_lo == 2'b01)
            return 3'd1;
        if (op == OP_STORE)
            return 3'd1;
        return 3'd0;
    endfunction

endpackage

// File: rtl/nanov_spi_shifter.sv
// nanov_spi_shifter: SPI flash link for the fetch sequencer.
// Sends {READ_CMD, addr} MSB-first after a start, then keeps chip select low
// so the flash keeps streaming; receive bits are placed so that a byte-serial,
// MSB-first stream lands as a little-endian 32-bit word.
//   clk, rst    : core clock, async active-high reset
//   start       : begin a new read at addr (cs_n falls on the next edge)
//   abort       : end the current read (cs_n rises on the next edge)
//   sck_run     : clock the flash this cycle
//   addr        : byte address captured on start
//   rx_en/rx_idx: sample spi_miso as stream bit rx_idx this cycle
//   spi_*       : flash pins (mosi, cs_n, SCK gate)
//   rx_word     : receive buffer including this cycle's bit
module nanov_spi_shifter
    import nanov_fetch_pkg::*;
#(
    parameter logic [7:0] READ_CMD = DEFAULT_READ_CMD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        sck_run,
    input  logic [23:0] addr,
    input  logic        rx_en,
    input  logic [4:0]  rx_idx,
    input  logic        spi_miso,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_sck_en,
    output logic [31:0] rx_word
);

    logic [31:0] tx_sr;
    logic [31:0] fetch_buf;
    logic        cs_n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_q    <= 1'b1;
            tx_sr     <= '0;
            fetch_buf <= '0;
        end else begin
            if (abort) begin
                cs_n_q <= 1'b1;
                tx_sr  <= '0;
            end else if (start) begin
                cs_n_q <= 1'b0;
                tx_sr  <= {READ_CMD, addr};
            end else if (sck_run && !cs_n_q) begin
                // Zeros shift in behind the header, so mosi idles low while
                // data streams back.
                tx_sr <= {tx_sr[30:0], 1'b0};
            end
            if (rx_en)
                fetch_buf <= rx_word;
        end
    end

    // Stream bit j is bit (7 - j%8) of byte j/8; byte k belongs at [8k+7:8k].
    always_comb begin
        rx_word = fetch_buf;
        if (rx_en)
            rx_word[{rx_idx[4:3], ~rx_idx[2:0]}] = spi_miso;
    end

    assign spi_cs_n   = cs_n_q;
    assign spi_sck_en = sck_run & ~cs_n_q;
    assign spi_mosi   = tx_sr[31] & ~cs_n_q;

endmodule

// File: rtl/nanov_fetch_sequencer.sv
// nanov_fetch_sequencer: fetches instructions from SPI flash and sequences the
// bit-serial core's execute phase (cycle/counter/shift strobe), redirecting on
// branch at the end of each instruction.
//   clk, rst        : core clock (also flash SCK when gated), async active-high reset
//   spi_*           : flash interface (see nanov_spi_shifter)
//   branch, branch_target : redirect request, sampled only at end of execute
//   instr, cycle, counter, shift_data_out, pc : execute-phase drive to the core
// Build option NANOV_FETCH_PREFETCH_EN: stream the next word during the last
// execute cycle so sequential instructions issue back-to-back.
module nanov_fetch_sequencer
    import nanov_fetch_pkg::*;
#(
    parameter logic [23:0] RESET_ADDR = 24'h000000,
    parameter logic [7:0]  READ_CMD   = DEFAULT_READ_CMD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_miso,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_sck_en,
    input  logic        branch,
    input  logic [23:0] branch_target,
    output logic [31:0] instr,
    output logic [2:0]  cycle,
    output logic [4:0]  counter,
    output logic        shift_data_out,
    output logic [23:0] pc
);

`ifdef NANOV_FETCH_PREFETCH_EN
    localparam logic PREFETCH = 1'b1;
`else
    localparam logic PREFETCH = 1'b0;
`endif

    fetch_state_t state;
    logic [4:0]   step;      // bit index within CMD/ADDR/FETCH
    logic [2:0]   last_cyc;
    logic         exec_last;
    logic         exec_end;
    logic         sck_run;
    logic         rx_en;
    logic [4:0]   rx_idx;
    logic [31:0]  rx_word;

    assign last_cyc  = last_cycle(instr[6:2], instr[13:12]);
    assign exec_last = (state == EXEC) && (cycle == last_cyc);
    assign exec_end  = exec_last && (counter == 5'd31);

    // With prefetch the last execute cycle doubles as the fetch of the next
    // word, using counter as the stream bit index.
    assign sck_run = (state == CMD) || (state == ADDR) || (state == FETCH) ||
                     (PREFETCH && exec_last);
    assign rx_en   = (state == FETCH) || (PREFETCH && exec_last);
    assign rx_idx  = (state == FETCH) ? step : counter;

    assign shift_data_out = (state == EXEC) && (instr[6:2] == OP_STORE) &&
                            (cycle == 3'd1);

    nanov_spi_shifter #(.READ_CMD(READ_CMD)) u_spi (
        .clk        (clk),
        .rst        (rst),
        .start      (state == IDLE),
        .abort      (exec_end && branch),
        .sck_run    (sck_run),
        .addr       (pc),
        .rx_en      (rx_en),
        .rx_idx     (rx_idx),
        .spi_miso   (spi_miso),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_sck_en (spi_sck_en),
        .rx_word    (rx_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            step    <= '0;
            instr   <= '0;
            cycle   <= '0;
            counter <= '0;
            pc      <= RESET_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    state <= CMD;
                    step  <= '0;
                end
                CMD: begin
                    if (step == 5'd7) begin
                        state <= ADDR;
                        step  <= '0;
                    end else begin
                        step <= step + 5'd1;
                    end
                end
                ADDR: begin
                    if (step == 5'd23) begin
                        state <= FETCH;
                        step  <= '0;
                    end else begin
                        step <= step + 5'd1;
                    end
                end
                FETCH: begin
                    if (step == 5'd31) begin
                        instr   <= rx_word;
                        state   <= EXEC;
                        cycle   <= '0;
                        counter <= '0;
                        step    <= '0;
                    end else begin
                        step <= step + 5'd1;
                    end
                end
                EXEC: begin
                    counter <= counter + 5'd1;
                    if (counter == 5'd31) begin
                        if (cycle < last_cyc) begin
                            cycle <= cycle + 3'd1;
                        end else begin
                            cycle <= '0;
                            if (branch) begin
                                // Redirect restarts the read; the shifter
                                // holds cs_n high through IDLE.
                                pc    <= branch_target & 24'hFFFFFC;
                                state <= IDLE;
                            end else begin
                                pc <= pc + 24'd4;
                                if (PREFETCH)
                                    instr <= rx_word;
                                else
                                    state <= FETCH;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_fetch_sequencer.sv
module tb_nanov_fetch_sequencer;

`ifdef NANOV_FETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_miso = 1'b0;
    logic        branch = 1'b0;
    logic [23:0] branch_target = '0;
    logic        spi_mosi, spi_cs_n, spi_sck_en, shift_data_out;
    logic [31:0] instr;
    logic [2:0]  cycle;
    logic [4:0]  counter;
    logic [23:0] pc;

    nanov_fetch_sequencer dut (
        .clk(clk), .rst(rst), .spi_miso(spi_miso), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_sck_en(spi_sck_en), .branch(branch),
        .branch_target(branch_target), .instr(instr), .cycle(cycle),
        .counter(counter), .shift_data_out(shift_data_out), .pc(pc)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:1023];
    int          total = 0;
    int          bad = 0;
    int          fl_bits = 0;
    logic [31:0] fl_hdr = '0;

    // Flash model: 32 header bits in, then bytes out MSB-first from the
    // header address, advancing only on gated SCK edges.
    always @(posedge clk) begin
        if (rst || spi_cs_n) begin
            fl_bits = 0;
        end else if (spi_sck_en) begin
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], spi_mosi};
            fl_bits = fl_bits + 1;
        end
    end

    always @(negedge clk) begin
        if (fl_bits >= 32) begin
            int off;
            logic [23:0] a;
            logic [7:0]  b;
            off = fl_bits - 32;
            a = fl_hdr[23:0] + 24'(off / 8);
            b = mem[a[9:0]];
            spi_miso = b[7 - (off % 8)];
        end else begin
            spi_miso = 1'b0;
        end
    end

    function automatic logic [31:0] rd_word(input logic [23:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    // Execute length in clocks, straight from the decode rules.
    function automatic int n_exec(input logic [31:0] w);
        int op;
        int f;
        op = int'(w[6:2]);
        f  = int'(w[13:12]);
        if ((op == 4 || op == 12) && f == 1) return 64;
        if (op == 8) return 64;
        return 32;
    endfunction

    task automatic wr_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[(a + i) % 1024] = w[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called during the IDLE clock; runs through CMD/ADDR/FETCH to the first
    // execute clock of the word at a.
    task automatic seq_from_idle(input logic [23:0] a);
        logic [7:0] cmd;
        cmd = 8'h03;
        chk("idle_cs_n", 32'(spi_cs_n), 32'd1);
        chk("idle_sck", 32'(spi_sck_en), 32'd0);
        chk("idle_pc", 32'(pc), 32'(a));
        tick(1);
        for (int i = 0; i < 8; i++) begin
            chk("cmd_mosi", 32'(spi_mosi), 32'(cmd[7 - i]));
            chk("cmd_cs_sck", 32'({spi_cs_n, spi_sck_en}), 32'd1);
            tick(1);
        end
        for (int i = 0; i < 24; i++) begin
            chk("addr_mosi", 32'(spi_mosi), 32'(a[23 - i]));
            tick(1);
        end
        chk("flash_hdr", fl_hdr, {8'h03, a});
        tick(32);
    endtask

    // Checks one instruction's execute phase starting at its first clock.
    task automatic exec_instr(input logic [23:0] epc, input bit br,
                              input logic [23:0] tgt, output logic [23:0] npc);
        logic [31:0] w;
        int n;
        bit st;
        w  = rd_word(epc);
        n  = n_exec(w);
        st = (w[6:2] == 5'b01000);
        chk("instr", instr, w);
        chk("pc", 32'(pc), 32'(epc));
        for (int k = 0; k < n; k++) begin
            chk("cycle", 32'(cycle), 32'(k / 32));
            chk("counter", 32'(counter), 32'(k % 32));
            chk("shift_data_out", 32'(shift_data_out), 32'(st && k >= 32));
            chk("exec_sck", 32'(spi_sck_en), 32'(PF && k >= n - 32));
            chk("exec_cs_n", 32'(spi_cs_n), 32'd0);
            // Random branch requests away from the end point must be ignored.
            branch        = (k == n - 1) ? br : 1'($urandom_range(0, 1));
            branch_target = (k == n - 1) ? tgt : 24'($urandom);
            tick(1);
        end
        branch = 1'b0;
        if (br) begin
            npc = tgt & 24'hFFFFFC;
            chk("br_pc", 32'(pc), 32'(npc));
            chk("br_cs_n", 32'(spi_cs_n), 32'd1);
        end else begin
            npc = epc + 24'd4;
            chk("seq_pc", 32'(pc), 32'(npc));
            if (!PF) begin
                chk("fetch_sck", 32'({spi_cs_n, spi_sck_en}), 32'd1);
                tick(32);
            end
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sck", 32'(spi_sck_en), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_cycle", 32'(cycle), 32'd0);
        chk("rst_counter", 32'(counter), 32'd0);
        chk("rst_sdo", 32'(shift_data_out), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
    endtask

    initial begin
        logic [23:0] p;
        logic [31:0] r;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        wr_word(0,  32'h00500093);
        wr_word(4,  32'h00209093);
        wr_word(8,  32'h00000013);
        wr_word(12, 32'h0020a023);
        r = $urandom;
        wr_word(16, {r[31:14], 1'b0, 2'b01, r[11:7], 5'b01100, 2'b11});
        r = $urandom;
        wr_word(256, {r[31:7], 5'b01000, r[1:0]});

        #12;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        seq_from_idle(24'h0);

        exec_instr(24'h0, 1'b0, 24'h0, p);
        exec_instr(p, 1'b0, 24'h0, p);
        exec_instr(p, 1'b0, 24'h0, p);
        exec_instr(p, 1'b0, 24'h0, p);
        exec_instr(p, 1'b0, 24'h0, p);
        exec_instr(p, 1'b1, 24'h000103, p);
        seq_from_idle(p);
        exec_instr(p, 1'b0, 24'h0, p);
        exec_instr(p, 1'b1, 24'hFFFFFC | 24'($urandom_range(0, 3)), p);
        seq_from_idle(p);
        exec_instr(p, 1'b0, 24'h0, p);
        chk("pc_wrap", 32'(p), 32'd0);
        exec_instr(p, 1'b1, {14'd0, 10'($urandom)}, p);

        // Reset in the middle of the address phase.
        tick(1 + 8 + 5);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        seq_from_idle(24'h0);
        exec_instr(24'h0, 1'b0, 24'h0, p);
        exec_instr(p, 1'b0, 24'h0, p);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
